// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and register bit indices
// Purpose: TX FSM state type, status/control bit positions used by the
//          register block, frame constants and the parity helper.
// Config : `UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

  localparam int UART_FRAME_DATA_BITS = 8;

  // Status register bit positions
  localparam int STAT_RX_VALID = 0;
  localparam int STAT_RX_FULL  = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_TX_FULL  = 3;
  localparam int STAT_INTR_EN  = 4;

  // Control register bit positions
  localparam int CTRL_RST_TX  = 0;
  localparam int CTRL_RST_RX  = 1;
  localparam int CTRL_EN_INTR = 4;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    TX_PARITY = 3'd4,
`endif
    TX_STOP   = 3'd3
  } tx_state_t;

  function automatic logic even_parity(input logic [UART_FRAME_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - generic synchronous FIFO with flush
// Purpose: byte queue shared by the TX and RX paths.
// Ports  : clk, rst (async, active-high); push_i/push_data_i write side;
//          pop_i read side with head_o always showing the oldest entry;
//          flush_i empties the queue; count_o occupancy; full_o.
module uart_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage needs no reset; only pointers/count define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointers wrap for free because DEPTH is a power of two.
  // Flush has priority, so a same-cycle push is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmit FIFO, baud divider and shifter
// Purpose: queues bytes from the register block and sends 8N1 frames on txd.
// Config : `UART_TX_PARITY_EN inserts an even-parity bit (8E1 frames).
// Ports  : clk, rst (async, active-high); wr_valid/wr_data/wr_ready byte
//          input; tx_flush clears the queue; tx_empty/tx_full status;
//          txd serial line, idle high.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic       tx_flush,
  output logic       tx_empty,
  output logic       tx_full,
  output logic       txd
);

  localparam int                BW        = $clog2(CLK_DIV);
  localparam logic [BW-1:0]     BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(UART_FRAME_DATA_BITS - 1);

  tx_state_t                     state_q;
  logic [BW-1:0]                 baud_q;
  logic [2:0]                    bit_idx_q;
  logic [7:0]                    shift_q;
  logic                          txd_q;
`ifdef UART_TX_PARITY_EN
  logic                          parity_q;
`endif

  logic [7:0]                    fifo_head;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          fifo_full;
  logic                          fifo_has_data;
  logic                          baud_done;
  logic                          pop;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (wr_valid),
    .push_data_i (wr_data),
    .pop_i       (pop),
    .flush_i     (tx_flush),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full)
  );

  assign fifo_has_data = (fifo_count != '0);
  assign baud_done     = (baud_q == BAUD_LAST);
  // Pop from IDLE, or at the end of a stop bit to chain frames without a gap.
  assign pop = fifo_has_data &&
               ((state_q == TX_IDLE) || ((state_q == TX_STOP) && baud_done));

  assign txd      = txd_q;
  assign wr_ready = !fifo_full;
  assign tx_full  = fifo_full;
  assign tx_empty = !fifo_has_data && (state_q == TX_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      if (state_q == TX_IDLE) baud_q <= '0;
      else                    baud_q <= baud_done ? '0 : baud_q + 1'b1;

      case (state_q)
        TX_IDLE: begin
          if (pop) begin
            shift_q <= fifo_head;
`ifdef UART_TX_PARITY_EN
            parity_q <= even_parity(fifo_head);
`endif
            txd_q   <= 1'b0;
            state_q <= TX_START;
          end
        end
        TX_START: begin
          if (baud_done) begin
            bit_idx_q <= '0;
            txd_q     <= shift_q[0];
            state_q   <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (baud_done) begin
            if (bit_idx_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              txd_q   <= parity_q;
              state_q <= TX_PARITY;
`else
              txd_q   <= 1'b1;
              state_q <= TX_STOP;
`endif
            end else begin
              // txd is registered, so drive the bit that becomes shift[0] next.
              shift_q   <= shift_q >> 1;
              txd_q     <= shift_q[1];
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        TX_PARITY: begin
          if (baud_done) begin
            txd_q   <= 1'b1;
            state_q <= TX_STOP;
          end
        end
`endif
        TX_STOP: begin
          if (baud_done) begin
            if (pop) begin
              shift_q <= fifo_head;
`ifdef UART_TX_PARITY_EN
              parity_q <= even_parity(fifo_head);
`endif
              txd_q   <= 1'b0;
              state_q <= TX_START;
            end else begin
              txd_q   <= 1'b1;
              state_q <= TX_IDLE;
            end
          end
        end
        default: begin
          txd_q   <= 1'b1;
          state_q <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - directed self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 16;
  localparam int TMO     = 300;
`ifdef UART_TX_PARITY_EN
  localparam int          NB      = 11;
  localparam logic [10:0] FRM_55  = 11'h4AA;
`else
  localparam int          NB      = 10;
  localparam logic [10:0] FRM_55  = 11'h2AA;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx_flush = 1'b0;
  logic       wr_ready;
  logic       tx_empty;
  logic       tx_full;
  logic       txd;

  int n_total = 0;
  int n_bad   = 0;

  logic [10:0] frm_a [17];
  int          wt_a  [17];
  bit          ok_a  [17];
  bit          acc;
  bit          last_acc;
  int          acc_n;
  int          zeros;
  bit          all_ok;

  always #5 clk = ~clk;

  uart_tx_serializer #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .tx_flush (tx_flush),
    .tx_empty (tx_empty),
    .tx_full  (tx_full),
    .txd      (txd)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  // Called at posedge+1; offers one byte for one cycle.
  task automatic push(input logic [7:0] d, output bit accepted);
    wr_valid = 1'b1;
    wr_data  = d;
    accepted = wr_ready;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  // Waits for a start bit, then samples every cycle of NB bits.
  // wait_n = idle cycles seen before the start bit; ok = every bit held CLK_DIV cycles.
  task automatic get_frame(output logic [10:0] frm, output int wait_n, output bit ok);
    frm = '0;
    wait_n = 0;
    ok = 1'b1;
    @(negedge clk);
    while (txd !== 1'b0 && wait_n < TMO) begin
      wait_n++;
      @(negedge clk);
    end
    if (txd !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < CLK_DIV; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (c == 0) frm[b] = txd;
        else if (txd !== frm[b]) ok = 1'b0;
      end
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_txd", 32'(txd), 32'd1);
    check_eq("rst_wr_ready", 32'(wr_ready), 32'd1);
    check_eq("rst_tx_empty", 32'(tx_empty), 32'd1);
    check_eq("rst_tx_full", 32'(tx_full), 32'd0);
    rst = 1'b0;
    align();

    // Single byte 0x55
    fork
      get_frame(frm_a[0], wt_a[0], ok_a[0]);
      push(8'h55, acc);
    join
    check_eq("single_frame", 32'(frm_a[0]), 32'(FRM_55));
    check_eq("single_stable", 32'(ok_a[0]), 32'd1);
    check_eq("single_latency", 32'(wt_a[0]), 32'd2);
    @(negedge clk);
    check_eq("single_empty_after", 32'(tx_empty), 32'd1);
    check_eq("single_txd_idle", 32'(txd), 32'd1);
    align();

    // Back-to-back 0xA5, 0x3C
    fork
      begin
        get_frame(frm_a[0], wt_a[0], ok_a[0]);
        get_frame(frm_a[1], wt_a[1], ok_a[1]);
      end
      begin
        push(8'hA5, acc);
        push(8'h3C, acc);
      end
    join
    check_eq("b2b_frame0", 32'(frm_a[0]), 32'(frame_of(8'hA5)));
    check_eq("b2b_frame1", 32'(frm_a[1]), 32'(frame_of(8'h3C)));
    check_eq("b2b_stable", 32'(ok_a[0] && ok_a[1]), 32'd1);
    check_eq("b2b_gap", 32'(wt_a[1]), 32'd0);
    @(negedge clk);
    check_eq("b2b_empty_after", 32'(tx_empty), 32'd1);
    align();

    // Full: one byte in the shifter, then 17 writes
    fork
      begin
        for (int i = 0; i < 17; i++) get_frame(frm_a[i], wt_a[i], ok_a[i]);
      end
      begin
        push(8'hE7, acc);
        repeat (2) align();
        acc_n = 0;
        for (int i = 0; i < 17; i++) begin
          push(8'(8'h10 + i), acc);
          if (acc) acc_n++;
          last_acc = acc;
        end
        check_eq("full_accepts", 32'(acc_n), 32'd16);
        check_eq("full_17th_rejected", 32'(last_acc), 32'd0);
        check_eq("full_tx_full", 32'(tx_full), 32'd1);
        check_eq("full_wr_ready", 32'(wr_ready), 32'd0);
      end
    join
    check_eq("full_frame_first", 32'(frm_a[0]), 32'(frame_of(8'hE7)));
    all_ok = 1'b1;
    for (int i = 1; i < 17; i++) begin
      check_eq($sformatf("full_frame_%0d", i), 32'(frm_a[i]), 32'(frame_of(8'(8'h10 + i - 1))));
      if (!ok_a[i] || wt_a[i] != 0) all_ok = 1'b0;
    end
    check_eq("full_stable_nogap", 32'(all_ok && ok_a[0]), 32'd1);
    @(negedge clk);
    check_eq("full_empty_after", 32'(tx_empty), 32'd1);
    align();

    // Flush during frame 1 DATA
    fork
      get_frame(frm_a[0], wt_a[0], ok_a[0]);
      begin
        push(8'hC4, acc);
        push(8'h81, acc);
        push(8'h42, acc);
        push(8'h99, acc);
        repeat (6) align();
        check_eq("flush_busy", 32'(tx_empty), 32'd0);
        tx_flush = 1'b1;
        align();
        tx_flush = 1'b0;
      end
    join
    check_eq("flush_frame1", 32'(frm_a[0]), 32'(frame_of(8'hC4)));
    check_eq("flush_stable", 32'(ok_a[0]), 32'd1);
    @(negedge clk);
    check_eq("flush_empty_after", 32'(tx_empty), 32'd1);
    zeros = 0;
    for (int i = 0; i < 15 * CLK_DIV; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) zeros++;
    end
    check_eq("flush_no_more_frames", 32'(zeros), 32'd0);
    align();

    // Reset during DATA bit 3
    push(8'hF0, acc);
    repeat (18) @(posedge clk);
    #2;
    check_eq("rstmid_bit3", 32'(txd), 32'd0);
    check_eq("rstmid_busy", 32'(tx_empty), 32'd0);
    rst = 1'b1;
    #1;
    check_eq("rstmid_txd_async", 32'(txd), 32'd1);
    align();
    rst = 1'b0;
    check_eq("rstmid_empty", 32'(tx_empty), 32'd1);
    check_eq("rstmid_wr_ready", 32'(wr_ready), 32'd1);
    zeros = 0;
    for (int i = 0; i < 12 * CLK_DIV; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) zeros++;
    end
    check_eq("rstmid_abandoned", 32'(zeros), 32'd0);
    align();

    // Recovery after reset
    fork
      get_frame(frm_a[0], wt_a[0], ok_a[0]);
      push(8'h3A, acc);
    join
    check_eq("recover_frame", 32'(frm_a[0]), 32'(frame_of(8'h3A)));
    check_eq("recover_stable", 32'(ok_a[0]), 32'd1);
    align();

`ifdef UART_TX_PARITY_EN
    fork
      begin
        get_frame(frm_a[0], wt_a[0], ok_a[0]);
        get_frame(frm_a[1], wt_a[1], ok_a[1]);
      end
      begin
        push(8'h07, acc);
        push(8'h03, acc);
      end
    join
    check_eq("parity_07", 32'(frm_a[0]), 32'h60E);
    check_eq("parity_03", 32'(frm_a[1]), 32'h406);
    check_eq("parity_stable", 32'(ok_a[0] && ok_a[1] && wt_a[1] == 0), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
